// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types: ALU opcode enum, funct3 encodings, width defaults
// and the forwarding-source selector used by the ID/EX operand muxes.
package riscv_pipe_pkg;

    localparam int XLEN_DEFAULT   = 32;
    localparam int REG_AW_DEFAULT = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_src_e;

    // x0 never forwards; the younger EX/MEM result beats MEM/WB.
    function automatic fwd_src_e fwd_select(input logic idx_zero,
                                            input logic mem_hit,
                                            input logic wb_hit);
        fwd_src_e src;
        src = FWD_REG;
        if (!idx_zero) begin
            if (mem_hit) begin
                src = FWD_MEM;
            end else if (wb_hit) begin
                src = FWD_WB;
            end
        end
        return src;
    endfunction

endpackage

// File: rtl/id_ex_stage_alu_ctrl.sv
// Combinational funct3/funct7b5 to ALU opcode decode, shared with later stages.
module alu_ctrl
    import riscv_pipe_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    input  logic       addr_calc,
    output alu_op_e    alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        if (!addr_calc) begin
            case (funct3)
                F3_ADD_SUB: alu_op = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
                F3_SLL:     alu_op = ALU_SLL;
                F3_SLT:     alu_op = ALU_SLT;
                F3_SLTU:    alu_op = ALU_SLTU;
                F3_XOR:     alu_op = ALU_XOR;
                F3_SR:      alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
                F3_OR:      alu_op = ALU_OR;
                F3_AND:     alu_op = ALU_AND;
                default:    alu_op = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use stall and flush.
// Optional build macro IDEX_PERF_CNT_EN adds saturating stall/flush counters.
module id_ex_stage
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic              in_is_rtype,
    input  logic              in_use_imm,
    input  logic              in_addr_calc,
    input  logic              in_is_load,
    input  logic              flush,
    input  logic              mem_we,
    input  logic              mem_is_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_opcode,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_is_load
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    logic              valid_reg;
    logic              valid_next;
    logic [REG_AW-1:0] rd_reg;
    logic [XLEN-1:0]   imm_reg;
    logic              use_imm_reg;
    logic              addr_calc_reg;
    logic              is_load_reg;
    alu_op_e           opcode_reg;
    alu_op_e           dec_op;

    logic                   hazard;
    logic                   capture;
    logic [1:0][REG_AW-1:0] in_rs_idx;
    logic [1:0][XLEN-1:0]   in_rs_data;
    logic [1:0][REG_AW-1:0] rs_idx;
    logic [1:0][XLEN-1:0]   fwd_data;

    assign in_rs_idx  = {in_rs2, in_rs1};
    assign in_rs_data = {in_rs2_data, in_rs1_data};

    // Stores (addr_calc) also need rs2 as store data, so rs2 counts even with an immediate.
    assign hazard = valid_reg & mem_is_load & mem_we & (mem_rd != '0) &
                    ((mem_rd == rs_idx[0]) |
                     ((!use_imm_reg | addr_calc_reg) & (mem_rd == rs_idx[1])));

    assign out_valid = valid_reg & !hazard;
    assign in_ready  = !valid_reg | (out_ready & !hazard);
    assign capture   = in_valid & in_ready & !flush;

    always_comb begin
        valid_next = valid_reg;
        if (flush) begin
            valid_next = 1'b0;
        end else if (capture) begin
            valid_next = 1'b1;
        end else if (valid_reg && out_ready && !hazard) begin
            valid_next = 1'b0;
        end
    end

    alu_ctrl u_alu_ctrl (
        .funct3    (in_funct3),
        .funct7b5  (in_funct7b5),
        .is_rtype  (in_is_rtype),
        .addr_calc (in_addr_calc),
        .alu_op    (dec_op)
    );

    // One operand slice per source register: index/data capture, late WB refresh, forward mux.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            logic [REG_AW-1:0] idx_reg;
            logic [XLEN-1:0]   data_reg;
            logic              mem_hit;
            logic              wb_hit;
            logic [XLEN-1:0]   fwd_val;

            assign mem_hit = mem_we & !mem_is_load & (mem_rd == idx_reg);
            assign wb_hit  = wb_we & (wb_rd == idx_reg);

            always_comb begin
                fwd_val = data_reg;
                case (fwd_select(idx_reg == '0, mem_hit, wb_hit))
                    FWD_MEM: fwd_val = mem_result;
                    FWD_WB:  fwd_val = wb_data;
                    default: fwd_val = data_reg;
                endcase
            end

            // A held instruction absorbs WB writes so the value survives the writer retiring.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    idx_reg  <= '0;
                    data_reg <= '0;
                end else if (capture) begin
                    idx_reg  <= in_rs_idx[gi];
                    data_reg <= in_rs_data[gi];
                end else if (valid_reg && wb_hit && idx_reg != '0) begin
                    data_reg <= wb_data;
                end
            end

            assign rs_idx[gi]   = idx_reg;
            assign fwd_data[gi] = fwd_val;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg     <= 1'b0;
            rd_reg        <= '0;
            imm_reg       <= '0;
            use_imm_reg   <= 1'b0;
            addr_calc_reg <= 1'b0;
            is_load_reg   <= 1'b0;
            opcode_reg    <= ALU_ADD;
        end else begin
            valid_reg <= valid_next;
            if (capture) begin
                rd_reg        <= in_rd;
                imm_reg       <= in_imm;
                use_imm_reg   <= in_use_imm;
                addr_calc_reg <= in_addr_calc;
                is_load_reg   <= in_is_load;
                opcode_reg    <= dec_op;
            end
        end
    end

    assign alu_a       = fwd_data[0];
    assign alu_b       = use_imm_reg ? imm_reg : fwd_data[1];
    assign out_rs2_val = fwd_data[1];
    assign alu_opcode  = opcode_reg;
    assign out_rd      = rd_reg;
    assign out_is_load = is_load_reg;

`ifdef IDEX_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hazard && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush && valid_reg && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a transaction-level model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [2:0]  in_funct3;
    logic        in_funct7b5, in_is_rtype, in_use_imm, in_addr_calc, in_is_load;
    logic        flush;
    logic        mem_we, mem_is_load;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a, alu_b, out_rs2_val;
    logic [3:0]  alu_opcode;
    logic [4:0]  out_rd;
    logic        out_is_load;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_is_rtype(in_is_rtype),
        .in_use_imm(in_use_imm), .in_addr_calc(in_addr_calc), .in_is_load(in_is_load),
        .flush(flush), .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_rd(mem_rd),
        .mem_result(mem_result), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_opcode(alu_opcode), .out_rs2_val(out_rs2_val), .out_rd(out_rd),
        .out_is_load(out_is_load)
`ifdef IDEX_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // The instruction the model believes is sitting in the stage.
    typedef struct {
        bit          v;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        bit          use_imm, addr_calc, is_load;
        logic [3:0]  op;
    } held_t;

    held_t m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_op(bit addr, logic [2:0] f3, bit f7, bit rt);
        if (addr) return 4'd0;
        case (f3)
            3'd0:    return (rt && f7) ? 4'd1 : 4'd0;
            3'd1:    return 4'd5;
            3'd2:    return 4'd8;
            3'd3:    return 4'd9;
            3'd4:    return 4'd4;
            3'd5:    return f7 ? 4'd7 : 4'd6;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(logic [4:0] idx, logic [31:0] cap);
        if (idx == 5'd0) return cap;
        if (mem_we && !mem_is_load && mem_rd == idx) return mem_result;
        if (wb_we && wb_rd == idx) return wb_data;
        return cap;
    endfunction

    function automatic bit ref_hazard();
        if (!(m.v && mem_we && mem_is_load && mem_rd != 5'd0)) return 1'b0;
        if (mem_rd == m.rs1) return 1'b1;
        return (!m.use_imm || m.addr_calc) && (mem_rd == m.rs2);
    endfunction

    task automatic model_reset();
        m = '{v: 1'b0, rs1: '0, rs2: '0, rd: '0, d1: '0, d2: '0, imm: '0,
              use_imm: 1'b0, addr_calc: 1'b0, is_load: 1'b0, op: '0};
    endtask

    task automatic idle();
        in_valid = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
        in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_funct3 = 0; in_funct7b5 = 0;
        in_is_rtype = 0; in_use_imm = 0; in_addr_calc = 0; in_is_load = 0;
        flush = 0; mem_we = 0; mem_is_load = 0; mem_rd = 0; mem_result = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0; out_ready = 1;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [2:0] f3, input bit f7, input bit rt, input bit ui);
        in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rs1_data = d1; in_rs2_data = d2; in_imm = imm;
        in_funct3 = f3; in_funct7b5 = f7; in_is_rtype = rt; in_use_imm = ui;
        in_addr_calc = 0; in_is_load = 0;
    endtask

    // Compare against the model, advance one clock, then update the model.
    task automatic step();
        bit hz, ev, er;
        logic [31:0] e2;
        #1;
        hz = ref_hazard();
        ev = m.v && !hz;
        er = !m.v || (out_ready && !hz);
        check("out_valid", {31'b0, out_valid}, {31'b0, ev});
        check("in_ready", {31'b0, in_ready}, {31'b0, er});
        if (ev) begin
            e2 = ref_fwd(m.rs2, m.d2);
            check("alu_a", alu_a, ref_fwd(m.rs1, m.d1));
            check("alu_b", alu_b, m.use_imm ? m.imm : e2);
            check("rs2_val", out_rs2_val, e2);
            check("opcode", {28'b0, alu_opcode}, {28'b0, m.op});
            check("out_rd", {27'b0, out_rd}, {27'b0, m.rd});
            check("is_load", {31'b0, out_is_load}, {31'b0, m.is_load});
            if (out_ready)
                $display("xfer rd=%0d a=%h b=%h op=%0d", out_rd, alu_a, alu_b, alu_opcode);
        end
        @(posedge clk);
        if (flush) begin
            m.v = 0;
        end else if (in_valid && er) begin
            m = '{v: 1'b1, rs1: in_rs1, rs2: in_rs2, rd: in_rd, d1: in_rs1_data,
                  d2: in_rs2_data, imm: in_imm, use_imm: in_use_imm,
                  addr_calc: in_addr_calc, is_load: in_is_load,
                  op: ref_op(in_addr_calc, in_funct3, in_funct7b5, in_is_rtype)};
        end else if (m.v && out_ready && !hz) begin
            m.v = 0;
        end else if (m.v && wb_we && wb_rd != 5'd0) begin
            if (wb_rd == m.rs1) m.d1 = wb_data;
            if (wb_rd == m.rs2) m.d2 = wb_data;
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 0;
        #1;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_a", alu_a, 32'd0);
        check("rst_b", alu_b, 32'd0);
        check("rst_op", {28'b0, alu_opcode}, 32'd0);
        check("rst_rd", {27'b0, out_rd}, 32'd0);
        @(negedge clk);
        rst_n = 1;

        // R-type SUB
        instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd3, 32'd0, 3'b000, 1, 1, 0);
        step();
        in_valid = 0; #1;
        check("sub_valid", {31'b0, out_valid}, 32'd1);
        check("sub_a", alu_a, 32'd5);
        check("sub_b", alu_b, 32'd3);
        check("sub_op", {28'b0, alu_opcode}, 32'd1);
        step();

        // EX/MEM beats MEM/WB
        instr(5'd7, 5'd0, 5'd8, 32'h11, 32'h0, 32'h0, 3'b000, 0, 0, 0);
        step();
        idle();
        mem_we = 1; mem_rd = 7; mem_result = 32'hAA; wb_we = 1; wb_rd = 7; wb_data = 32'hBB;
        #1;
        check("fwd_prio", alu_a, 32'hAA);
        step();
        instr(5'd0, 5'd0, 5'd8, 32'h55, 32'h0, 32'h0, 3'b000, 0, 0, 0);
        mem_we = 0; wb_we = 0;
        step();
        idle();
        mem_we = 1; mem_rd = 0; mem_result = 32'hAA; wb_we = 1; wb_rd = 0; wb_data = 32'hBB;
        #1;
        check("fwd_x0", alu_a, 32'h55);
        step();

        // Load-use stall then WB refresh of the held operand
        idle();
        instr(5'd4, 5'd9, 5'd10, 32'h99, 32'h0, 32'h8, 3'b000, 0, 0, 1);
        step();
        instr(5'd1, 5'd1, 5'd1, 32'h1, 32'h1, 32'h0, 3'b000, 0, 0, 0);
        mem_we = 1; mem_is_load = 1; mem_rd = 4;
        #1;
        check("lu_valid", {31'b0, out_valid}, 32'd0);
        check("lu_ready", {31'b0, in_ready}, 32'd0);
        step();
        idle();
        in_valid = 0; wb_we = 1; wb_rd = 4; wb_data = 32'h1234; out_ready = 0;
        #1;
        check("lu_wb_valid", {31'b0, out_valid}, 32'd1);
        check("lu_wb_a", alu_a, 32'h1234);
        step();
        wb_we = 0; out_ready = 1;
        #1;
        check("lu_keep_a", alu_a, 32'h1234);
        step();

        // Backpressure, then flush with an incoming instruction
        idle();
        instr(5'd1, 5'd2, 5'd3, 32'hF0, 32'h0F, 32'h0, 3'b100, 0, 1, 0);
        step();
        instr(5'd5, 5'd6, 5'd7, 32'h1, 32'h2, 32'h0, 3'b110, 0, 1, 0);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", {31'b0, in_ready}, 32'd0);
            check("bp_a", alu_a, 32'hF0);
            check("bp_b", alu_b, 32'h0F);
            check("bp_op", {28'b0, alu_opcode}, 32'd4);
            step();
        end
        flush = 1;
        step();
        flush = 0; in_valid = 0; out_ready = 1;
        #1;
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        step();
        check("flush_gone", {31'b0, out_valid}, 32'd0);

        // SRAI
        idle();
        instr(5'd3, 5'd5, 5'd4, 32'h80000000, 32'h0, 32'h405, 3'b101, 1, 0, 1);
        step();
        in_valid = 0; #1;
        check("srai_op", {28'b0, alu_opcode}, 32'd7);
        check("srai_b", alu_b, 32'h405);
        check("srai_valid", {31'b0, out_valid}, 32'd1);

        // Asynchronous reset mid-transfer
        out_ready = 0;
        step();
        #2;
        rst_n = 0;
        #1;
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_op", {28'b0, alu_opcode}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        idle();
        #1;
        check("arst_ready", {31'b0, in_ready}, 32'd1);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            in_valid     = ($urandom_range(0, 9) < 7);
            in_rs1       = 5'($urandom_range(0, 5));
            in_rs2       = 5'($urandom_range(0, 5));
            in_rd        = 5'($urandom_range(0, 31));
            in_rs1_data  = $urandom;
            in_rs2_data  = $urandom;
            in_imm       = $urandom;
            in_funct3    = 3'($urandom_range(0, 7));
            in_funct7b5  = 1'($urandom_range(0, 1));
            in_is_rtype  = 1'($urandom_range(0, 1));
            in_use_imm   = 1'($urandom_range(0, 1));
            in_addr_calc = ($urandom_range(0, 3) == 0);
            in_is_load   = in_addr_calc && $urandom_range(0, 1) == 1;
            flush        = ($urandom_range(0, 9) == 0);
            mem_we       = 1'($urandom_range(0, 1));
            mem_is_load  = ($urandom_range(0, 9) < 3);
            mem_rd       = 5'($urandom_range(0, 5));
            mem_result   = $urandom;
            wb_we        = 1'($urandom_range(0, 1));
            wb_rd        = 5'($urandom_range(0, 5));
            wb_data      = $urandom;
            out_ready    = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
